criq_free_list: RTL and testbench

CRIQ_FREE_LIST -- requirements
Module: criq_free_list

---
 rtl/criq_free_list.sv | 123 ++++++++++++
 tb/tb_criq_free_list.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/criq_free_list.sv
// Two-lane circular free list of tags with compacted allocate/free lanes.
// Starts full with an arithmetic tag sequence; reset and flush restore it.
module criq_free_list #(
   parameter int CRIQWIDE = 6,
   parameter int CRIQDEEP = 32,
   parameter int INITBASE = 0,
   parameter int INITSTEP = 1
) (
   input  logic                              Clk,
   input  logic                              Rest,
   input  logic [1:0]                        Rable,
   output logic [CRIQWIDE-1:0]               Dout0,
   output logic [CRIQWIDE-1:0]               Dout1,
   output logic [1:0]                        DoutValid,
   output logic [CRIQWIDE-1:0]               PreOut0,
   output logic [CRIQWIDE-1:0]               PreOut1,
   input  logic [1:0]                        Wable,
   input  logic [CRIQWIDE-1:0]               Din0,
   input  logic [CRIQWIDE-1:0]               Din1,
   input  logic                              CriqClean,
   output logic [$clog2(CRIQDEEP+1)-1:0]     CriqCount,
   output logic                              CriqFull,
   output logic                              CriqEmpty,
   output logic                              CriqAvail2,
   output logic                              CriqErr
);

   localparam int AW = (CRIQDEEP > 1) ? $clog2(CRIQDEEP) : 1;
   localparam int CW = $clog2(CRIQDEEP + 1);
   localparam logic [CW-1:0] FULLCNT = CW'(CRIQDEEP);

   logic [CRIQWIDE-1:0] mem [CRIQDEEP];
   logic [AW-1:0]       head, tail, head1, tail1;
   logic [CW-1:0]       count, count_next;
   logic [1:0]          nr, nw;
   logic                rd_ok, wr_ok, rd_go, wr_go;
   logic [CRIQWIDE-1:0] wd0;

   // Modular add of 0..2 without requiring a power-of-two depth.
   function automatic logic [AW-1:0] ptr_add(
      input logic [AW-1:0] p,
      input logic [1:0]    n
   );
      logic [AW+1:0] s;
      s = {2'b00, p} + {{AW{1'b0}}, n};
      if (s >= (AW+2)'(CRIQDEEP))
         s = s - (AW+2)'(CRIQDEEP);
      return s[AW-1:0];
   endfunction

   always_comb begin
      nr    = {1'b0, Rable[0]} + {1'b0, Rable[1]};
      nw    = {1'b0, Wable[0]} + {1'b0, Wable[1]};
      rd_ok = CW'(nr) <= count;
      wr_ok = CW'(nw) <= (FULLCNT - count);
      rd_go = (|Rable) && rd_ok;
      wr_go = (|Wable) && wr_ok;
      head1 = ptr_add(head, 2'd1);
      tail1 = ptr_add(tail, 2'd1);
      wd0   = Wable[0] ? Din0 : Din1;
      count_next = count;
      if (wr_go)
         count_next = count_next + CW'(nw);
      if (rd_go)
         count_next = count_next - CW'(nr);
   end

   always_ff @(posedge Clk) begin
      if (Rest || CriqClean) begin
         for (int k = 0; k < CRIQDEEP; k++)
            mem[k] <= CRIQWIDE'(INITBASE + k * INITSTEP);
      end else if (wr_go) begin
         mem[tail] <= wd0;
         if (nw == 2'd2)
            mem[tail1] <= Din1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rest || CriqClean) begin
         head  <= '0;
         tail  <= '0;
         count <= FULLCNT;
      end else begin
         if (rd_go)
            head <= ptr_add(head, nr);
         if (wr_go)
            tail <= ptr_add(tail, nw);
         count <= count_next;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rest) begin
         Dout0     <= '0;
         Dout1     <= '0;
         DoutValid <= 2'b00;
      end else if (CriqClean) begin
         DoutValid <= 2'b00;
      end else begin
         DoutValid <= rd_go ? Rable : 2'b00;
         if (rd_go && Rable[0])
            Dout0 <= mem[head];
         if (rd_go && Rable[1])
            Dout1 <= Rable[0] ? mem[head1] : mem[head];
      end
   end

   always_ff @(posedge Clk) begin
      if (Rest)
         CriqErr <= 1'b0;
      else if (!CriqClean && (((|Rable) && !rd_ok) || ((|Wable) && !wr_ok)))
         CriqErr <= 1'b1;
   end

   assign PreOut0    = mem[head];
   assign PreOut1    = mem[head1];
   assign CriqCount  = count;
   assign CriqFull   = count == FULLCNT;
   assign CriqEmpty  = count == '0;
   assign CriqAvail2 = count >= CW'(2);

endmodule

// File: tb/tb_criq_free_list.sv
// Scoreboard bench for criq_free_list: a FIFO reference of free tags
// predicts allocations; expectations are queued per cycle and popped after.
module tb_criq_free_list;

   logic       Clk;
   logic       Rest;
   logic [1:0] Rable, Wable;
   logic [5:0] Din0, Din1;
   logic       CriqClean;
   logic [5:0] Dout0, Dout1, PreOut0, PreOut1;
   logic [1:0] DoutValid;
   logic [5:0] CriqCount;
   logic       CriqFull, CriqEmpty, CriqAvail2, CriqErr;

   logic [5:0] u2_d0, u2_d1, u2_p0, u2_p1;
   logic [1:0] u2_dv;
   logic [5:0] u2_cnt;
   logic       u2_full, u2_empty, u2_av2, u2_err;

   criq_free_list dut (
      .Clk(Clk), .Rest(Rest), .Rable(Rable),
      .Dout0(Dout0), .Dout1(Dout1), .DoutValid(DoutValid),
      .PreOut0(PreOut0), .PreOut1(PreOut1),
      .Wable(Wable), .Din0(Din0), .Din1(Din1),
      .CriqClean(CriqClean), .CriqCount(CriqCount),
      .CriqFull(CriqFull), .CriqEmpty(CriqEmpty),
      .CriqAvail2(CriqAvail2), .CriqErr(CriqErr)
   );

   criq_free_list #(.INITBASE(2), .INITSTEP(4)) u2 (
      .Clk(Clk), .Rest(Rest), .Rable(Rable),
      .Dout0(u2_d0), .Dout1(u2_d1), .DoutValid(u2_dv),
      .PreOut0(u2_p0), .PreOut1(u2_p1),
      .Wable(Wable), .Din0(Din0), .Din1(Din1),
      .CriqClean(CriqClean), .CriqCount(u2_cnt),
      .CriqFull(u2_full), .CriqEmpty(u2_empty),
      .CriqAvail2(u2_av2), .CriqErr(u2_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0] dv;
      logic [5:0] d0;
      logic [5:0] d1;
      logic       err;
      int         cnt;
      logic [5:0] p0;
      logic [5:0] p1;
   } exp_t;

   exp_t       sb[$];
   logic [5:0] fl[$];
   logic [5:0] m_d0, m_d1;
   logic       m_err;
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_init();
      fl.delete();
      for (int k = 0; k < 32; k++)
         fl.push_back(6'(k));
   endtask

   task automatic step(input logic rst, input logic [1:0] r,
                       input logic [1:0] w, input logic [5:0] a,
                       input logic [5:0] b, input logic cl);
      exp_t e;
      int   n_r, n_w, sz;
      Rest = rst; Rable = r; Wable = w;
      Din0 = a; Din1 = b; CriqClean = cl;
      n_r = int'(r[0]) + int'(r[1]);
      n_w = int'(w[0]) + int'(w[1]);
      sz = fl.size();
      e.dv = 2'b00;
      if (rst) begin
         model_init();
         m_d0 = '0; m_d1 = '0; m_err = 1'b0;
      end else if (cl) begin
         model_init();
      end else begin
         if (n_r > 0 && n_r <= sz) begin
            e.dv = r;
            if (r == 2'b11) begin
               m_d0 = fl.pop_front();
               m_d1 = fl.pop_front();
            end else if (r == 2'b01) begin
               m_d0 = fl.pop_front();
            end else begin
               m_d1 = fl.pop_front();
            end
         end else if (n_r > 0) begin
            m_err = 1'b1;
         end
         if (n_w > 0 && n_w <= 32 - sz) begin
            if (w[0]) fl.push_back(a);
            if (w[1]) fl.push_back(b);
         end else if (n_w > 0) begin
            m_err = 1'b1;
         end
      end
      e.d0 = m_d0; e.d1 = m_d1; e.err = m_err;
      e.cnt = fl.size();
      e.p0 = (fl.size() > 0) ? fl[0] : 6'h0;
      e.p1 = (fl.size() > 1) ? fl[1] : 6'h0;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      chk("dv", 32'(DoutValid), 32'(e.dv));
      chk("d0", 32'(Dout0), 32'(e.d0));
      chk("d1", 32'(Dout1), 32'(e.d1));
      chk("err", 32'(CriqErr), 32'(e.err));
      chk("cnt", 32'(CriqCount), 32'(e.cnt));
      chk("full", 32'(CriqFull), 32'(e.cnt == 32));
      chk("empty", 32'(CriqEmpty), 32'(e.cnt == 0));
      chk("av2", 32'(CriqAvail2), 32'(e.cnt >= 2));
      if (e.cnt >= 1) chk("pre0", 32'(PreOut0), 32'(e.p0));
      if (e.cnt >= 2) chk("pre1", 32'(PreOut1), 32'(e.p1));
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 2'b00, 6'h0, 6'h0, 1'b0);
   endtask

   task automatic rd(input logic [1:0] r);
      step(1'b0, r, 2'b00, 6'h0, 6'h0, 1'b0);
   endtask

   task automatic wr(input logic [1:0] w, input logic [5:0] a,
                     input logic [5:0] b);
      step(1'b0, 2'b00, w, a, b, 1'b0);
   endtask

   task automatic rst();
      step(1'b1, 2'b11, 2'b11, 6'h3f, 6'h3f, 1'b1);
   endtask

   initial begin
      m_d0 = '0; m_d1 = '0; m_err = 1'b0;
      model_init();
      rst();
      rst();
      chk("rst_pre0", 32'(PreOut0), 32'd0);
      chk("rst_pre1", 32'(PreOut1), 32'd1);
      chk("u2_rst_pre0", 32'(u2_p0), 32'd2);
      chk("u2_rst_pre1", 32'(u2_p1), 32'd6);
      rd(2'b11);
      chk("first_d0", 32'(Dout0), 32'd0);
      chk("first_d1", 32'(Dout1), 32'd1);

      rst();
      rd(2'b10);
      rd(2'b01);
      chk("lane_d0", 32'(Dout0), 32'd1);

      rst();
      for (int i = 0; i < 16; i++) rd(2'b11);
      rd(2'b01);
      chk("under_err", 32'(CriqErr), 32'd1);

      // park head at 30 and tail at 31 so the paired write wraps to 0
      rst();
      for (int i = 0; i < 15; i++) rd(2'b11);
      rd(2'b01);
      for (int i = 0; i < 15; i++)
         wr(2'b11, 6'($urandom), 6'($urandom));
      wr(2'b01, 6'($urandom), 6'h0);
      for (int i = 0; i < 15; i++) rd(2'b11);
      rd(2'b01);
      step(1'b0, 2'b01, 2'b11, 6'd40, 6'd41, 1'b0);
      rd(2'b11);
      chk("wrap_d0", 32'(Dout0), 32'd40);
      chk("wrap_d1", 32'(Dout1), 32'd41);

      rst();
      wr(2'b01, 6'd9, 6'd0);
      chk("over_err", 32'(CriqErr), 32'd1);
      rd(2'b11);
      step(1'b0, 2'b11, 2'b11, 6'd50, 6'd51, 1'b0);
      chk("rw_cnt", 32'(CriqCount), 32'd30);

      for (int i = 0; i < 300; i++)
         step(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              6'($urandom), 6'($urandom), $urandom_range(0, 19) == 0);
      step(1'b0, 2'b11, 2'b11, 6'd7, 6'd8, 1'b1);
      chk("clean_pre0", 32'(PreOut0), 32'd0);
      chk("u2_clean_pre0", 32'(u2_p0), 32'd2);
      chk("u2_clean_pre1", 32'(u2_p1), 32'd6);
      for (int i = 0; i < 16; i++) rd(2'b11);

      rd(2'b01);
      step(1'b1, 2'b11, 2'b11, 6'd1, 6'd2, 1'b0);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
